ysyx_22040895_pcu: RTL

- PC update and instruction-fetch control unit; the consumer of the branch/jump redirect that the branch compare unit produces (jump_branch + dnpc).
- Holds the architectural fetch PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Delivers fetched instructions downstream to decode over a valid/ready handshake.
- On redirect: squashes in-flight or held instructions and refetches from dnpc.

---
 rtl/ysyx_22040895_pcu.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ysyx_22040895_pcu.sv
// PC update and instruction-fetch control: one outstanding imem request, redirect squash.
// Optional misaligned-redirect trap: define YSYX_22040895_PCU_MISALIGN_TRAP_EN.
module ysyx_22040895_pcu #(
    parameter int XLEN = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000),
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            jump_branch_i,
    input  logic [XLEN-1:0] dnpc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [ILEN-1:0] imem_rsp_data_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [ILEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic            misalign_o
);

    typedef enum logic [1:0] {
        S_RST,
        S_REQ,
        S_WAIT,
        S_OUT
    } state_t;

    state_t          state_q, state_n;
    logic [XLEN-1:0] pc_q, pc_n;
    logic            disc_q, disc_n;
    logic [ILEN-1:0] inst_q, inst_n;
    logic [XLEN-1:0] pco_q, pco_n;

    logic            take;
    logic [XLEN-1:0] tgt;
    logic            active;

    assign active = (state_q != S_RST);

`ifdef YSYX_22040895_PCU_MISALIGN_TRAP_EN
    logic mis_q;
    logic mis_hit;

    // A misaligned target is reported and the redirect is ignored.
    assign mis_hit    = active && jump_branch_i && (dnpc_i[1:0] != 2'b00);
    assign take       = active && jump_branch_i && (dnpc_i[1:0] == 2'b00);
    assign tgt        = dnpc_i;
    assign misalign_o = mis_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else if (mis_hit) begin
            mis_q <= 1'b1;
        end
    end
`else
    assign take       = active && jump_branch_i;
    assign tgt        = dnpc_i & ~XLEN'(3);
    assign misalign_o = 1'b0;
`endif

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        disc_n  = disc_q;
        inst_n  = inst_q;
        pco_n   = pco_q;
        unique case (state_q)
            S_RST: begin
                state_n = S_REQ;
            end
            S_REQ: begin
                if (take) begin
                    pc_n = tgt;
                end
                if (imem_req_ready_i) begin
                    state_n = S_WAIT;
                    disc_n  = take;
                end
            end
            S_WAIT: begin
                if (take) begin
                    pc_n = tgt;
                    if (imem_rsp_valid_i) begin
                        state_n = S_REQ;
                        disc_n  = 1'b0;
                    end else begin
                        disc_n = 1'b1;
                    end
                end else if (imem_rsp_valid_i) begin
                    if (disc_q) begin
                        state_n = S_REQ;
                        disc_n  = 1'b0;
                    end else begin
                        state_n = S_OUT;
                        inst_n  = imem_rsp_data_i;
                        pco_n   = pc_q;
                    end
                end
            end
            S_OUT: begin
                if (take) begin
                    pc_n    = tgt;
                    state_n = S_REQ;
                end else if (inst_ready_i) begin
                    pc_n    = pc_q + XLEN'(4);
                    state_n = S_REQ;
                end
            end
            default: begin
                state_n = S_RST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RST;
            pc_q    <= RESET_PC;
            disc_q  <= 1'b0;
            inst_q  <= '0;
            pco_q   <= '0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            disc_q  <= disc_n;
            inst_q  <= inst_n;
            pco_q   <= pco_n;
        end
    end

    assign imem_req_valid_o = (state_q == S_REQ);
    assign imem_addr_o      = pc_q;
    assign inst_valid_o     = (state_q == S_OUT);
    assign inst_o           = inst_q;
    assign pc_o             = pco_q;

endmodule
